// File: rtl/div_pkg.sv
// Shared types and defaults for the multi-cycle restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

    // Divider FSM states: IDLE waits for start, CALC runs one trial
    // subtraction per cycle, FIX applies signs and publishes results.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it is
// non-negative, otherwise restore the shifted remainder.
module div_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] div,
    input  logic             q_in_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*div and the WIDTH+1-bit trial sign bit is a valid borrow flag.
    always_comb begin
        shifted  = {rem, q_in_bit};
        trial    = shifted - {1'b0, div};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle signed/unsigned integer divider using the restoring algorithm.
//
// Handshake: start is sampled only on an edge where busy is low; that edge
// captures signed_op/dividend/divisor. busy is high from that edge until the
// edge at which done falls, so a start held during the done cycle is ignored
// and must still be high in the following cycle to be accepted. done is a
// one-cycle pulse; quotient/remainder/div_by_zero hold until the next result.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output state_t           state_dbg
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] div_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    // Magnitudes of the incoming operands; only signed requests take abs.
    always_comb begin
        abs_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        abs_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    div_sub_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_r),
        .div      (div_r),
        .q_in_bit (q_r[WIDTH-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign state_dbg = state;

    // Divider FSM: operand capture, WIDTH shift-subtract cycles, sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            div_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // busy still high here means this is the done cycle.
                    if (!busy && start) begin
                        busy    <= 1'b1;
                        rem_r   <= '0;
                        counter <= CNT_W'(WIDTH - 1);
                        div_r   <= abs_divisor;
                        neg_q   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r   <= signed_op & dividend[WIDTH-1];
                        if (divisor == '0) begin
                            // Zero path keeps the raw dividend to return as remainder.
                            dz    <= 1'b1;
                            q_r   <= dividend;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            q_r   <= abs_dividend;
                            state <= CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= rem_next;
                    q_r   <= {q_r[WIDTH-2:0], q_bit};
                    if (counter == '0) begin
                        state <= FIX;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= q_r;
                    end else begin
                        quotient  <= neg_q ? -q_r : q_r;
                        remainder <= neg_r ? -rem_r : rem_r;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: hand-computed vectors, latency,
// divide-by-zero, signed overflow, start-while-busy and async reset abort.
module tb_restoring_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    state_t       state_dbg;

    int total = 0;
    int bad   = 0;

    // expected quotient, remainder, div_by_zero per accepted operation
    logic [W-1:0] exp_q[$];

    restoring_divider #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dzf);
        exp_q.push_back(q);
        exp_q.push_back(r);
        exp_q.push_back({{(W-1){1'b0}}, dzf});
    endtask

    // drive one start pulse; returns at the negedge after the sampling edge
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // wait for done (n0 edges already seen counting the sampling edge),
    // then check latency and results against the scoreboard; stays in done cycle
    task automatic wait_done(input string tag, input int lat, input int n0);
        int   n;
        logic seen;
        logic [W-1:0] eq, er, ed;
        n    = n0;
        seen = 1'b0;
        if (done) seen = 1'b1;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, W'(seen), W'(1));
        check({tag, "_latency"}, W'(n), W'(lat));
        check({tag, "_busy_in_done"}, W'(busy), W'(1));
        if (exp_q.size() >= 3) begin
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            ed = exp_q.pop_front();
            check({tag, "_quotient"}, quotient, eq);
            check({tag, "_remainder"}, remainder, er);
            check({tag, "_div_by_zero"}, W'(div_by_zero), ed);
        end else begin
            check({tag, "_scoreboard_empty"}, W'(exp_q.size()), W'(3));
        end
    endtask

    // one more cycle: done must drop and the unit become idle
    task automatic finish_op(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_fall"}, W'(done), W'(0));
        check({tag, "_busy_fall"}, W'(busy), W'(0));
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat);
        start_op(s, a, b);
        check({tag, "_busy_rise"}, W'(busy), W'(1));
        wait_done(tag, lat, 1);
        finish_op(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quotient", quotient, W'(0));
        check("rst_remainder", remainder, W'(0));
        check("rst_dz", W'(div_by_zero), W'(0));
        check("rst_state", W'(state_dbg), W'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // basic unsigned and signed vectors
        push_exp(32'd14, 32'd2, 1'b0);
        run_op("u100_7", 1'b0, 32'd100, 32'd7, W + 2);
        push_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, W + 2);
        push_exp(32'h7FFF_FFFC, 32'h1, 1'b0);
        run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, W + 2);
        push_exp(32'h8000_0000, 32'h0, 1'b0);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, W + 2);
        push_exp(32'h0FFF_FFFF, 32'hF, 1'b0);
        run_op("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, W + 2);
        push_exp(32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
        run_op("s_m21_m4", 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFC, W + 2);

        // divide by zero in both modes
        push_exp(32'hFFFF_FFFF, 32'h1234, 1'b1);
        run_op("u_div0", 1'b0, 32'h1234, 32'h0, 2);
        push_exp(32'hFFFF_FFFF, 32'h1234, 1'b1);
        run_op("s_div0", 1'b1, 32'h1234, 32'h0, 2);

        // start pulsed mid-CALC with new operands, then inputs disturbed
        push_exp(32'd14, 32'd2, 1'b0);
        start_op(1'b0, 32'd100, 32'd7);
        check("mid_state_calc", W'(state_dbg), W'(CALC));
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'd999;
        divisor  = 32'd0;
        wait_done("mid_ignore", W + 2, 7);
        finish_op("mid_ignore");

        // start held through done: second op accepted the cycle after done
        push_exp(32'd66, 32'd2, 1'b0);
        start_op(1'b0, 32'd200, 32'd3);
        start = 1'b1;
        wait_done("held_first", W + 2, 1);
        dividend = 32'd81;
        divisor  = 32'd9;
        @(posedge clk);
        @(negedge clk);
        check("held_not_in_done", W'(busy), W'(0));
        check("held_done_fall", W'(done), W'(0));
        push_exp(32'd9, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held_accept", W'(busy), W'(1));
        wait_done("held_second", W + 2, 1);
        finish_op("held_second");

        // async reset during CALC iteration 10
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_quotient", quotient, W'(0));
        check("abort_remainder", remainder, W'(0));
        check("abort_state", W'(state_dbg), W'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", W'(done), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        push_exp(32'd100, 32'd0, 1'b0);
        run_op("post_reset", 1'b0, 32'd1000, 32'd10, W + 2);

        check("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
